// File: rtl/sobel_pkg.sv
// Shared widths, constants and arithmetic helpers for the Sobel edge detector.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 16;
  localparam int GRAD_W  = 11;
  localparam int MAG_W   = 12;

  // Largest value the 8-bit output can carry; larger magnitudes clamp to it.
  localparam logic [PIX_W-1:0] SAT_VAL = 8'd255;
  localparam logic [MAG_W-1:0] SAT_MAG = 12'd255;

  // Sobel kernel weights: outer taps 1, centre tap 2.
  localparam int W_EDGE = 1;
  localparam int W_MID  = 2;

  // Weighted 1-2-1 sum of three pixels. Max 1020, so it fits the signed gradient width.
  function automatic logic signed [GRAD_W-1:0] weighted_sum(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b,
    input logic [PIX_W-1:0] c
  );
    logic [GRAD_W-1:0] s;
    s = GRAD_W'(a) * GRAD_W'(W_EDGE) + GRAD_W'(b) * GRAD_W'(W_MID) + GRAD_W'(c) * GRAD_W'(W_EDGE);
    return signed'(s);
  endfunction

  // Absolute value of a gradient; |-1020| still fits in GRAD_W bits.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] n;
    n = -g;
    return g[GRAD_W-1] ? unsigned'(n) : unsigned'(g);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage, indexed by column. Reads are combinational, so the
// value read in an accept cycle is the one stored before that cycle's write.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic               clk,
  input  logic               en,
  input  logic [COORD_W-1:0] addr,
  input  logic [PIX_W-1:0]   wdata,
  output logic [PIX_W-1:0]   rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic             in_range;
  logic [AW-1:0]    idx;

  // Columns beyond the buffer only occur in frames that are too wide; those
  // frames never produce output, so such accesses are simply dropped.
  assign in_range = (addr < COORD_W'(DEPTH));
  assign idx      = addr[AW-1:0];
  assign rdata    = in_range ? mem[idx] : '0;

  // Store the incoming pixel for use by the next row.
  always_ff @(posedge clk) begin
    if (en && in_range) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector over a raster-order 8-bit gray stream.
// Handshake: in_valid qualifies in_pixel and is always accepted (no ready);
// out_valid qualifies out_pixel/out_x/out_y for exactly one cycle (no ready).
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int          MAX_W  = 640,
  parameter int unsigned THRESH = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic [COORD_W-1:0] W,
  input  logic [COORD_W-1:0] H,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_pixel,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               frame_done
);

  logic [COORD_W-1:0] x_in, y_in, w_r, h_r;
  logic               x_last, y_last, frame_ok, win_done;
  logic [PIX_W-1:0]   lb0_q, lb1_q;
  logic [PIX_W-1:0]   win [3][3];  // win[row][col], row 0 = oldest row, col 0 = leftmost

  logic                      v0, last0;
  logic [COORD_W-1:0]        x0, y0;
  logic                      v1, last1;
  logic [COORD_W-1:0]        x1, y1;
  logic signed [GRAD_W-1:0]  gx1, gy1;
  logic                      v2, last2;
  logic [COORD_W-1:0]        x2, y2;
  logic [PIX_W-1:0]          pix2;
  logic [MAG_W-1:0]          mag;
  logic [PIX_W-1:0]          pix_d;

  assign x_last   = (x_in == w_r - COORD_W'(1));
  assign y_last   = (y_in == h_r - COORD_W'(1));
  assign frame_ok = (w_r >= COORD_W'(3)) && (w_r <= COORD_W'(MAX_W)) && (h_r >= COORD_W'(3));
  assign win_done = frame_ok && (x_in >= COORD_W'(2)) && (y_in >= COORD_W'(2));

  // Raster counters; frame size is captured at reset and at each frame end only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_in <= '0;
      y_in <= '0;
      w_r  <= W;
      h_r  <= H;
    end else if (in_valid) begin
      if (x_last) begin
        x_in <= '0;
        if (y_last) begin
          y_in <= '0;
          w_r  <= W;
          h_r  <= H;
        end else begin
          y_in <= y_in + COORD_W'(1);
        end
      end else begin
        x_in <= x_in + COORD_W'(1);
      end
    end
  end

  // lb0 holds row y-1; its old contents cascade into lb1 (row y-2).
  sobel_line_buffer #(.DEPTH(MAX_W)) u_lb0 (
    .clk   (clk),
    .en    (in_valid),
    .addr  (x_in),
    .wdata (in_pixel),
    .rdata (lb0_q)
  );

  sobel_line_buffer #(.DEPTH(MAX_W)) u_lb1 (
    .clk   (clk),
    .en    (in_valid),
    .addr  (x_in),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // Shift the 3x3 window one column left on every accepted pixel.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= in_pixel;
    end
  end

  // Stage 0 tags: window completeness and the centre coordinate travel with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v0    <= 1'b0;
      last0 <= 1'b0;
      x0    <= '0;
      y0    <= '0;
    end else begin
      v0    <= in_valid && win_done;
      last0 <= x_last && y_last;
      x0    <= x_in - COORD_W'(1);
      y0    <= y_in - COORD_W'(1);
    end
  end

  // Stage 1: horizontal and vertical gradients.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      gx1   <= '0;
      gy1   <= '0;
    end else begin
      v1    <= v0;
      last1 <= last0;
      x1    <= x0;
      y1    <= y0;
      gx1   <= weighted_sum(win[0][2], win[1][2], win[2][2])
             - weighted_sum(win[0][0], win[1][0], win[2][0]);
      gy1   <= weighted_sum(win[2][0], win[2][1], win[2][2])
             - weighted_sum(win[0][0], win[0][1], win[0][2]);
    end
  end

  // L1 magnitude, then either clamp to 8 bits or binarise against the threshold.
  always_comb begin
    mag   = MAG_W'(abs_grad(gx1)) + MAG_W'(abs_grad(gy1));
    pix_d = '0;
    if (THRESH == 0) begin
      pix_d = (mag > SAT_MAG) ? SAT_VAL : mag[PIX_W-1:0];
    end else begin
      pix_d = (32'(mag) >= THRESH) ? SAT_VAL : '0;
    end
  end

  // Stage 2: registered edge value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      x2    <= '0;
      y2    <= '0;
      pix2  <= '0;
    end else begin
      v2    <= v1;
      last2 <= last1;
      x2    <= x1;
      y2    <= y1;
      pix2  <= pix_d;
    end
  end

  // Output register; frame_done marks the bottom-right interior pixel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid  <= v2;
      frame_done <= v2 && last2;
      out_pixel  <= pix2;
      out_x      <= x2;
      out_y      <= y2;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Bench for sobel_edge: two instances (saturated and thresholded output) share
// one input stream; a frame-level reference model fills an expected queue.
module tb_sobel_edge;

  localparam int MAX_W = 16;
  localparam int THR   = 50;

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  pix;
    logic [7:0]  pix_t;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic [15:0] W = '0;
  logic [15:0] H = '0;

  logic        out_valid, frame_done, out_valid_t, frame_done_t;
  logic [7:0]  out_pixel, out_pixel_t;
  logic [15:0] out_x, out_y, out_x_t, out_y_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  img [0:511];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          out_cnt = 0;
  int          exp_cnt = 0;
  int          mark = 0;
  int          mark_e = 0;
  logic        mon_en = 1'b0;
  int          rw [7];
  int          rh [7];

  sobel_edge #(.MAX_W(MAX_W), .THRESH(0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pixel(in_pixel), .W(W), .H(H),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done)
  );

  sobel_edge #(.MAX_W(MAX_W), .THRESH(THR)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pixel(in_pixel), .W(W), .H(H),
    .out_valid(out_valid_t), .out_pixel(out_pixel_t), .out_x(out_x_t), .out_y(out_y_t),
    .frame_done(frame_done_t)
  );

  // Clock and free-running cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit frame_legal(input int w, input int h);
    return (w >= 3) && (w <= MAX_W) && (h >= 3);
  endfunction

  function automatic int pix_at(input int w, input int x, input int y);
    return int'(img[y * w + x]);
  endfunction

  function automatic int sobel_mag(input int w, input int cx, input int cy);
    int gx, gy;
    int wt [3];
    wt = '{1, 2, 1};
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      gx += wt[k] * (pix_at(w, cx + 1, cy - 1 + k) - pix_at(w, cx - 1, cy - 1 + k));
      gy += wt[k] * (pix_at(w, cx - 1 + k, cy + 1) - pix_at(w, cx - 1 + k, cy - 1));
    end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  // ---------------- image fills ----------------
  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int n, input int v);
    for (int i = 0; i < n; i++) img[i] = 8'(v);
  endtask

  task automatic fill_hramp(input int w, input int h, input int step);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y * w + x] = 8'(step * x);
  endtask

  task automatic fill_step(input int w, input int h, input int edge_col);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y * w + x] = (x >= edge_col) ? 8'd255 : 8'd0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic accept_pixel(input logic [7:0] p, input int wv, input int hv);
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = p;
    W = 16'(wv);
    H = 16'(hv);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Drive npix pixels of a w x h frame; on its last pixel present the next frame's size.
  task automatic run_frame(input int w, input int h, input int nw, input int nh,
                           input int gap, input int npix);
    int   x, y, m;
    logic last;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      x = i % w;
      y = i / w;
      last = (i == w * h - 1);
      accept_pixel(img[i], last ? nw : w, last ? nh : h);
      if (frame_legal(w, h) && x >= 2 && y >= 2) begin
        m = sobel_mag(w, x - 1, y - 1);
        e.due   = 32'(acc_cyc + 3);
        e.x     = 16'(x - 1);
        e.y     = 16'(y - 1);
        e.pix   = (m > 255) ? 8'd255 : 8'(m);
        e.pix_t = (m >= THR) ? 8'd255 : 8'd0;
        e.last  = last;
        exp_q.push_back(e);
        exp_cnt++;
      end
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic do_reset(input int wv, input int hv, input int n);
    @(negedge clk);
    rstn = 1'b0;
    in_valid = 1'b0;
    W = 16'(wv);
    H = 16'(hv);
    idle(n);
    #1;
    exp_q.delete();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_out_pixel", 32'(out_pixel), 0);
    check("rst_out_x", 32'(out_x), 0);
    check("rst_out_y", 32'(out_y), 0);
    check("rst_out_valid_t", 32'(out_valid_t), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain_count(input string tag, input int want);
    idle(8);
    #1;
    check(tag, 32'(out_cnt - mark), 32'(want));
    check("queue_empty", 32'(exp_q.size()), 0);
    mark = out_cnt;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("done_without_valid", 32'(frame_done & ~out_valid), 0);
      if (out_valid) begin
        check("out_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_cycle", 32'(cyc), mon_e.due);
          check("out_x", 32'(out_x), 32'(mon_e.x));
          check("out_y", 32'(out_y), 32'(mon_e.y));
          check("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
          check("frame_done", 32'(frame_done), 32'(mon_e.last));
          check("thr_valid", 32'(out_valid_t), 1);
          check("thr_pixel", 32'(out_pixel_t), 32'(mon_e.pix_t));
          check("thr_x", 32'(out_x_t), 32'(mon_e.x));
          check("thr_y", 32'(out_y_t), 32'(mon_e.y));
          check("thr_done", 32'(frame_done_t), 32'(mon_e.last));
          out_cnt++;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    do_reset(5, 3, 2);
    mon_en = 1'b1;

    // Vertical step edge, 5x3: outputs 0, 255, 255.
    fill_step(5, 3, 3);
    run_frame(5, 3, 4, 4, 0, 15);
    drain_count("count_step_5x3", 3);

    // Flat 4x4 frame: four zero outputs.
    fill_const(16, 77);
    run_frame(4, 4, 3, 3, 0, 16);
    drain_count("count_flat_4x4", 4);

    // 3x3 horizontal ramp: single output 80 (255 when thresholded at 50).
    fill_hramp(3, 3, 10);
    run_frame(3, 3, 3, 3, 0, 9);
    drain_count("count_ramp_3x3", 1);

    // Random frame sizes for the back-to-back section; one is wider than MAX_W.
    for (int k = 0; k < 6; k++) begin
      rw[k] = $urandom_range(3, 8);
      rh[k] = $urandom_range(3, 6);
    end
    rw[2] = MAX_W + 2;
    rh[2] = 3;
    rw[6] = 5;
    rh[6] = 5;

    // Same ramp with random input gaps.
    fill_hramp(3, 3, 10);
    run_frame(3, 3, rw[0], rh[0], 2, 9);
    drain_count("count_ramp_gaps", 1);

    // Back-to-back random frames.
    mark_e = exp_cnt;
    for (int k = 0; k < 6; k++) begin
      fill_random(rw[k] * rh[k]);
      run_frame(rw[k], rh[k], rw[k + 1], rh[k + 1], k % 2, rw[k] * rh[k]);
    end
    drain_count("count_random", exp_cnt - mark_e);

    // Abort a 5x5 frame after seven pixels, then a full 5x5 frame.
    fill_random(25);
    run_frame(5, 5, 5, 5, 0, 7);
    do_reset(5, 5, 1);
    mark = out_cnt;
    fill_random(25);
    run_frame(5, 5, 2, 4, 0, 25);
    drain_count("count_after_abort", 9);

    // Too-narrow frame latched at reset emits nothing; the next 4x4 frame works.
    do_reset(2, 4, 1);
    mark = out_cnt;
    fill_random(8);
    run_frame(2, 4, 4, 4, 0, 8);
    drain_count("count_narrow", 0);
    fill_random(16);
    run_frame(4, 4, 4, 4, 1, 16);
    drain_count("count_after_narrow", 4);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector. It sits directly downstream of the RGB-to-grayscale stage and consumes its 8-bit gray pixel stream in raster order. It emits the gradient magnitude of every interior pixel, so the output frame is (W-2)x(H-2). Results feed the frame writer and display path.

## Interface
Parameters:
- MAX_W, 640: line-buffer depth; largest supported frame width.
- THRESH, 0: 0 selects saturated magnitude output; nonzero selects binary output (255 if magnitude >= THRESH, else 0).

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous and active-low.
- in_valid  in  1  in_pixel valid this cycle; no backpressure; every valid cycle is accepted.
- in_pixel  in  8  gray pixel, raster order.
- W  in  16  frame width, legal range 3..MAX_W.
- H  in  16  frame height, legal range >= 3.
- out_valid  out  1  out_pixel/out_x/out_y valid this cycle.
- out_pixel  out  8  edge value.
- out_x  out  16  column of window centre, 1..W-2.
- out_y  out  16  row of window centre, 1..H-2.
- frame_done  out  1  one-cycle pulse, coincident with the last out_valid of a frame.

## Operation
- Input column counter x_in: 0..W-1. Input row counter y_in: 0..H-1. Both advance only on in_valid.
  - x_in wraps at W-1, then y_in increments.
  - At (W-1,H-1) both wrap to 0.
- W and H latch into internal registers w_r and h_r on reset and on the accept of the last pixel of each frame. Mid-frame changes on W/H are ignored.
- If the latched w_r or h_r is illegal (w_r < 3, w_r > MAX_W, or h_r < 3):
  - counters still run;
  - out_valid and frame_done stay 0 for the whole frame.
- Two line buffers hold rows y-1 and y-2, each MAX_W x 8, indexed by x_in. On an accepted pixel:
  - lb1[x_in] is read into the row y-2 tap;
  - lb0[x_in] is read into the row y-1 tap and written into lb1[x_in];
  - in_pixel is written into lb0[x_in].
  - Read-before-write at the same address is required.
- 3x3 window: three 3-deep column shift registers, shifted only on accept.
- The window is complete when the accepted pixel has x_in >= 2 and y_in >= 2. Its centre is (x_in-1, y_in-1).
- Arithmetic:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - Gx and Gy are 11-bit signed, range ±1020.
  - mag = |Gx| + |Gy|, 12-bit unsigned, max 2040.
  - Saturated output: min(mag, 255).
- Pixels in rows 0 and H-1 and columns 0 and W-1 produce no output.

## Timing
- Pipeline:
  - Stage 0 (accept cycle): counters advance, line buffers read/write, window shifts.
  - Stage 1: Gx and Gy registered.
  - Stage 2: magnitude, saturation and threshold registered.
- Output appears 3 clk after the accept edge of the completing pixel: accept at edge n, out_valid high after edge n+3.
- Each output is valid for exactly one cycle. Gaps in in_valid propagate as gaps in out_valid.
- Pipeline stages advance every cycle regardless of in_valid, so the final outputs drain without further input.
- frame_done rises together with out_valid for centre (w_r-2, h_r-2).
- Reset values:
  - out_valid, frame_done: 0.
  - out_pixel, out_x, out_y: 0.
  - Counters: 0.
  - Pipeline valid bits: 0.
  - Line-buffer contents are not reset; stale data never reaches an output because rows 0 and 1 emit nothing.
- Reset mid-frame: everything above returns to reset values on the reset edge. Any in-flight results are discarded. The next accepted pixel is treated as (0,0).
- Back-to-back frames need no idle cycle. The first pixel of frame k+1 may be accepted on the cycle after the last pixel of frame k.

## Structure
- Package sobel_pkg:
  - PIX_W=8, COORD_W=16, GRAD_W=11, MAG_W=12;
  - saturation constant 255;
  - Sobel weight constants.
- Sub-module sobel_line_buffer: single-port, read-before-write, depth MAX_W, 8 bits wide. Instantiated twice.
- Top level holds the counters, W/H latch, window registers and the two arithmetic stages.

## Test plan
- W=5, H=3, THRESH=0, each row 0,0,0,255,255:
  - out (1,1)=0, (2,1)=255, (3,1)=255;
  - frame_done with (3,1);
  - first out_valid 3 clk after accept of pixel (2,2).
- W=4, H=4, every pixel 77:
  - four outputs, all 0, at centres (1,1),(2,1),(1,2),(2,2);
  - frame_done on (2,2).
- W=3, H=3, horizontal ramp 0,10,20 per row: single output (1,1)=80; THRESH=50 variant gives 255.
- Same ramp as the previous case with in_valid toggling 1-0-0-1 at random:
  - identical values and coordinates;
  - out_valid count equals (W-2)(H-2).
- rstn low for 1 cycle at pixel 7 of a 5x5 frame, then a full 5x5 frame:
  - no outputs from the aborted frame;
  - nine correct outputs afterwards.
- W=2 latched at reset: a full 2x4 frame accepted with out_valid and frame_done never asserted. Then W=4 latched for the next frame, which outputs normally.
